// File: rtl/sonic_vc_rx_pkt_fifo_pkg.sv
// Shared definitions for the SONIC VC receive packet FIFO: stored-word
// layout, write-side FSM states and statistics counter width.
package sonic_vc_pkg;

  // Statistics counters (pkt_count, drop_count) width
  localparam int CNT_W = 16;

  // Stored word is {sop, eop, empty, data}; data sits at bit 0
  localparam int OFF_DATA = 0;

  function automatic int off_empty(input int data_w);
    return data_w;
  endfunction

  function automatic int off_eop(input int data_w, input int empty_w);
    return data_w + empty_w;
  endfunction

  function automatic int off_sop(input int data_w, input int empty_w);
    return data_w + empty_w + 1;
  endfunction

  function automatic int word_w(input int data_w, input int empty_w);
    return data_w + empty_w + 2;
  endfunction

  // Write-side packet FSM
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_e;

endpackage

// File: rtl/sonic_vc_rx_pkt_fifo_if.sv
// Avalon-ST beat bundle. The producer side uses the master modport, the
// consumer side uses the slave modport.
interface sonic_vc_rx_pkt_fifo_if #(
  parameter int DATA_W  = 128,
  parameter int EMPTY_W = 2
) ();

  logic [DATA_W-1:0]  data;
  logic [EMPTY_W-1:0] empty;
  logic               startofpacket;
  logic               endofpacket;
  logic               error;
  logic               valid;
  logic               ready;

  modport master (
    output data, empty, startofpacket, endofpacket, error, valid,
    input  ready
  );

  modport slave (
    input  data, empty, startofpacket, endofpacket, error, valid,
    output ready
  );

endinterface

// File: rtl/sonic_vc_rx_pkt_fifo_ram.sv
// Simple dual-port buffer RAM: one write port, one read port with a
// registered output that holds its value when no read is issued.
module sonic_vc_rx_pkt_ram #(
  parameter int WORD_W = 132,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port: storage array carries no reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read port: registered output, cleared by reset so the source bus idles at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sonic_vc_rx_pkt_fifo.sv
// Store-and-forward receive packet FIFO. Beats are written speculatively
// behind commit_ptr; a clean eop advances commit_ptr so the packet becomes
// readable, while errored, truncated or overflowing packets rewind wr_ptr
// back to commit_ptr and bump drop_count.
module sonic_vc_rx_pkt_fifo
  import sonic_vc_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int EMPTY_W    = 2,
  parameter int DEPTH_LOG2 = 13
) (
  input  logic                   wrclock,
  input  logic                   reset_n,
  sonic_vc_rx_pkt_fifo_if.slave  avalonst_sink,
  sonic_vc_rx_pkt_fifo_if.master avalonst_source,
  output logic [DEPTH_LOG2:0]    level,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int PTR_W     = DEPTH_LOG2 + 1;
  localparam int WORD_W    = word_w(DATA_W, EMPTY_W);
  localparam int EMPTY_LSB = off_empty(DATA_W);
  localparam int EOP_BIT   = off_eop(DATA_W, EMPTY_W);
  localparam int SOP_BIT   = off_sop(DATA_W, EMPTY_W);

  // Occupancy value that marks the buffer as completely full
  localparam logic [PTR_W-1:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  // Saturating add used by the drop counter
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  wr_state_e         state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr, commit_ptr, rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_d, commit_ptr_d, wr_base, occ;
  logic              sink_ready_q;
  logic              beat_p0, take_p0, full_p0, we_p0;
  logic              sop_p0, eop_p0, err_p0;
  logic [1:0]        drop_inc;
  logic              commit_inc;
  logic              rd_en_p0;
  logic              vld_p1;
  logic              eop_out_p1;
  logic [WORD_W-1:0] wr_word_p0;
  logic [WORD_W-1:0] rd_word_p1;

  // ---- stage p0: accepted sink beat, write decision ----
  assign beat_p0    = sink_ready_q & avalonst_sink.valid;
  assign sop_p0     = avalonst_sink.startofpacket;
  assign eop_p0     = avalonst_sink.endofpacket;
  assign err_p0     = avalonst_sink.error;
  assign wr_word_p0 = {sop_p0, eop_p0, avalonst_sink.empty, avalonst_sink.data};

  // Write FSM next state, pointer rewinds/commits and counter increments.
  // A sop arriving mid-packet abandons the open packet first, so the new
  // packet's room check is made against commit_ptr rather than wr_ptr.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr;
    commit_ptr_d = commit_ptr;
    wr_base      = wr_ptr;
    take_p0      = 1'b0;
    full_p0      = 1'b0;
    occ          = '0;
    we_p0        = 1'b0;
    drop_inc     = 2'd0;
    commit_inc   = 1'b0;
    if (beat_p0) begin
      unique case (state_q)
        RECV: begin
          take_p0 = 1'b1;
          if (sop_p0) begin
            drop_inc = 2'd1;
            wr_base  = commit_ptr;
          end
        end
        default: begin
          if (sop_p0)              take_p0  = 1'b1;
          else if (state_q == IDLE) drop_inc = 2'd1;
          else if (eop_p0)          state_d  = IDLE;
        end
      endcase
      if (take_p0) begin
        occ     = wr_base - rd_ptr;
        full_p0 = (occ == FULL_LVL);
        if (full_p0) begin
          drop_inc = drop_inc + 2'd1;
          wr_ptr_d = commit_ptr;
          state_d  = eop_p0 ? IDLE : DROP;
        end else begin
          we_p0 = 1'b1;
          if (eop_p0 && err_p0) begin
            drop_inc = drop_inc + 2'd1;
            wr_ptr_d = commit_ptr;
            state_d  = IDLE;
          end else if (eop_p0) begin
            wr_ptr_d     = wr_base + PTR_W'(1);
            commit_ptr_d = wr_base + PTR_W'(1);
            commit_inc   = 1'b1;
            state_d      = IDLE;
          end else begin
            wr_ptr_d = wr_base + PTR_W'(1);
            state_d  = RECV;
          end
        end
      end
    end
  end

  // Write-side state: FSM, pointers, sink ready and drop counter
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      wr_ptr       <= '0;
      commit_ptr   <= '0;
      sink_ready_q <= 1'b0;
      drop_count   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr       <= wr_ptr_d;
      commit_ptr   <= commit_ptr_d;
      sink_ready_q <= 1'b1;
      drop_count   <= sat_add(drop_count, drop_inc);
    end
  end

  // Only committed words are ever read, so reads never chase the write pointer
  assign rd_en_p0 = avalonst_source.ready & (rd_ptr != commit_ptr);

  // Read pointer and output-valid pipeline
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (rd_en_p0) rd_ptr <= rd_ptr + PTR_W'(1);
      vld_p1 <= rd_en_p0;
    end
  end

  sonic_vc_rx_pkt_ram #(
    .WORD_W (WORD_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .clk   (wrclock),
    .rst_n (reset_n),
    .we    (we_p0),
    .waddr (wr_base[DEPTH_LOG2-1:0]),
    .wdata (wr_word_p0),
    .re    (rd_en_p0),
    .raddr (rd_ptr[DEPTH_LOG2-1:0]),
    .rdata (rd_word_p1)
  );

  // ---- stage p1: registered RAM word presented on the source ----
  assign eop_out_p1 = vld_p1 & rd_word_p1[EOP_BIT];

  // Packet count rises on commit and falls once a packet's eop has been emitted
  always_ff @(posedge wrclock or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else begin
      unique case ({commit_inc, eop_out_p1})
        2'b10:   pkt_count <= pkt_count + CNT_W'(1);
        2'b01:   pkt_count <= pkt_count - CNT_W'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  assign level = commit_ptr - rd_ptr;

  assign avalonst_sink.ready = sink_ready_q;

  assign avalonst_source.data          = rd_word_p1[OFF_DATA +: DATA_W];
  assign avalonst_source.empty         = rd_word_p1[EMPTY_LSB +: EMPTY_W];
  assign avalonst_source.startofpacket = rd_word_p1[SOP_BIT];
  assign avalonst_source.endofpacket   = rd_word_p1[EOP_BIT];
  assign avalonst_source.error         = 1'b0;
  assign avalonst_source.valid         = vld_p1;

endmodule

// File: tb/tb_sonic_vc_rx_pkt_fifo.sv
// Bench for the receive packet FIFO: a table of single-packet cases run
// with the consumer stalled, followed by hand-written sequences for latency,
// truncation, ready toggling and mid-traffic reset. A scoreboard queue holds
// the beats expected on the source side.
module tb_sonic_vc_rx_pkt_fifo;

  localparam int DATA_W     = 128;
  localparam int EMPTY_W    = 2;
  localparam int DEPTH_LOG2 = 4;

  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
    logic [DATA_W-1:0]  data;
  } word_t;

  typedef struct {
    int nbeats;
    bit sop;
    bit err;
    bit exp_out;
    int exp_level;
    int exp_pkt;
    int exp_drop;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [DEPTH_LOG2:0] level;
  logic [15:0] pkt_count, drop_count;

  sonic_vc_rx_pkt_fifo_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) snk_if ();
  sonic_vc_rx_pkt_fifo_if #(.DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) src_if ();

  sonic_vc_rx_pkt_fifo #(
    .DATA_W     (DATA_W),
    .EMPTY_W    (EMPTY_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .wrclock         (clk),
    .reset_n         (reset_n),
    .avalonst_sink   (snk_if),
    .avalonst_source (src_if),
    .level           (level),
    .pkt_count       (pkt_count),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  int    n_total = 0;
  int    n_pass  = 0;
  int    cyc     = 0;
  int    out_cnt = 0;
  int    sop_cyc = -100;
  int    eop_cyc = 0;
  bit    rdy_prev = 1'b0;
  word_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Source monitor: every emitted beat must be expected, in order, and
  // must follow a cycle in which the consumer was ready
  always @(negedge clk) begin
    word_t got, want;
    if (reset_n && src_if.valid) begin
      out_cnt++;
      check("valid_after_ready", rdy_prev, 1);
      check("source_error", src_if.error, 0);
      got = {src_if.startofpacket, src_if.endofpacket, src_if.empty, src_if.data};
      check("beat_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        want = exp_q.pop_front();
        check("beat_word", got, want);
      end
      if (src_if.startofpacket) sop_cyc = cyc;
    end
    rdy_prev = src_if.ready;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One beat per cycle; error is randomised on non-eop beats since only
  // the eop beat's error flag may matter
  task automatic send_beats(input int n, input bit first_sop, input bit last_eop,
                            input bit err, input bit expect_out);
    word_t w;
    for (int i = 0; i < n; i++) begin
      w.sop   = first_sop && (i == 0);
      w.eop   = last_eop && (i == n - 1);
      w.empty = w.eop ? EMPTY_W'($urandom) : '0;
      w.data  = {$urandom, $urandom, $urandom, $urandom};
      snk_if.data          = w.data;
      snk_if.empty         = w.empty;
      snk_if.startofpacket = w.sop;
      snk_if.endofpacket   = w.eop;
      snk_if.error         = w.eop ? err : 1'($urandom);
      snk_if.valid         = 1'b1;
      if (expect_out) exp_q.push_back(w);
      if (w.eop) eop_cyc = cyc;
      @(posedge clk);
      #1;
    end
    snk_if.valid         = 1'b0;
    snk_if.startofpacket = 1'b0;
    snk_if.endofpacket   = 1'b0;
    snk_if.error         = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    idle(3);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, src_if.valid, 0);
    check({tag, "_sink_ready"}, snk_if.ready, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_pkt_count"}, pkt_count, 0);
    check({tag, "_drop_count"}, drop_count, 0);
    check({tag, "_src_word"},
          {src_if.startofpacket, src_if.endofpacket, src_if.empty, src_if.data}, 0);
  endtask

  vec_t tbl[8];

  initial begin
    int exp_drop;
    int base_cnt;

    // nbeats sop err out level pkt drop(cumulative)
    tbl[0] = '{4,  1, 0, 1, 4,  1, 0};
    tbl[1] = '{3,  1, 1, 0, 0,  0, 1};
    tbl[2] = '{2,  1, 0, 1, 2,  1, 1};
    tbl[3] = '{1,  0, 0, 0, 0,  0, 2};
    tbl[4] = '{1,  1, 0, 1, 1,  1, 2};
    tbl[5] = '{1,  1, 1, 0, 0,  0, 3};
    tbl[6] = '{16, 1, 0, 1, 16, 1, 3};
    tbl[7] = '{20, 1, 0, 0, 0,  0, 4};

    snk_if.data          = '0;
    snk_if.empty         = '0;
    snk_if.startofpacket = 1'b0;
    snk_if.endofpacket   = 1'b0;
    snk_if.error         = 1'b0;
    snk_if.valid         = 1'b0;
    src_if.ready         = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    reset_n = 1'b1;
    idle(1);
    check("sink_ready_rise", snk_if.ready, 1);

    // Table: each packet sent with the consumer stalled, then drained
    for (int t = 0; t < 8; t++) begin
      src_if.ready = 1'b0;
      send_beats(tbl[t].nbeats, tbl[t].sop, 1'b1, tbl[t].err, tbl[t].exp_out);
      idle(2);
      check($sformatf("row%0d_level", t), level, tbl[t].exp_level);
      check($sformatf("row%0d_pkt_count", t), pkt_count, tbl[t].exp_pkt);
      check($sformatf("row%0d_drop_count", t), drop_count, tbl[t].exp_drop);
      src_if.ready = 1'b1;
      drain();
      check($sformatf("row%0d_level_drained", t), level, 0);
      check($sformatf("row%0d_pkt_drained", t), pkt_count, 0);
    end
    exp_drop = 4;

    // After the overflow, the next 4-beat packet commits fully
    src_if.ready = 1'b0;
    send_beats(4, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);
    check("post_ovf_level", level, 4);
    src_if.ready = 1'b1;
    drain();

    // Latency: first valid beat two cycles after the eop cycle
    src_if.ready = 1'b1;
    send_beats(4, 1'b1, 1'b1, 1'b0, 1'b1);
    check("lat_pkt_count_1", pkt_count, 1);
    drain();
    check("lat_sop_delay", sop_cyc - eop_cyc, 2);
    check("lat_pkt_count_0", pkt_count, 0);
    check("lat_drop_count", drop_count, exp_drop);

    // Truncated packet followed by a fresh sop
    send_beats(2, 1'b1, 1'b0, 1'b0, 1'b0);
    send_beats(2, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    exp_drop++;
    check("trunc_drop_count", drop_count, exp_drop);

    // Ten single-beat packets with the consumer toggling ready each cycle
    base_cnt = out_cnt;
    for (int i = 0; i < 30; i++) begin
      src_if.ready = (i % 2 == 0);
      if (i < 10) send_beats(1, 1'b1, 1'b1, 1'b0, 1'b1);
      else        idle(1);
    end
    src_if.ready = 1'b1;
    drain();
    check("toggle_out_count", out_cnt - base_cnt, 10);
    check("toggle_pkt_count", pkt_count, 0);

    // Reset while three packets are committed and a fourth is partial
    src_if.ready = 1'b0;
    for (int p = 0; p < 3; p++) send_beats(2, 1'b1, 1'b1, 1'b0, 1'b1);
    send_beats(2, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    check("pre_rst_pkt_count", pkt_count, 3);
    check("pre_rst_level", level, 6);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    src_if.ready = 1'b1;
    base_cnt = out_cnt;
    idle(1);
    check("rst_sink_ready", snk_if.ready, 1);
    idle(10);
    check("rst_no_stale", out_cnt - base_cnt, 0);
    send_beats(3, 1'b1, 1'b1, 1'b0, 1'b1);
    drain();
    check("rst_new_out_count", out_cnt - base_cnt, 3);
    check("rst_drop_count", drop_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sonic_vc_rx_pkt_fifo.md
# sonic_vc_rx_pkt_fifo

Store-and-forward receive packet FIFO for the SONIC virtual-channel datapath, the receive-direction counterpart of the VC transmit FIFO. It accepts 128-bit Avalon-ST beats from the receive-side producer without backpressure. It forwards only complete, error-free packets to the VC consumer. Truncated, errored and overflowing packets are rewound out of the buffer and counted.

## Interface
- `DATA_W`, 128, payload width.
- `EMPTY_W`, 2, empty-symbol field width.
- `DEPTH_LOG2`, 13, log2 of buffer depth in beats (8192).
- `wrclock`  in  1  sole clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `avalonst_sink_data`  in  DATA_W  beat payload.
- `avalonst_sink_empty`  in  EMPTY_W  empty symbols on eop beat.
- `avalonst_sink_startofpacket`  in  1  first beat.
- `avalonst_sink_endofpacket`  in  1  last beat.
- `avalonst_sink_error`  in  1  packet bad; sampled on eop beat only.
- `avalonst_sink_valid`  in  1  beat present.
- `avalonst_sink_ready`  out  1  0 in reset, 1 otherwise (no backpressure).
- `avalonst_source_data`  out  DATA_W  forwarded payload.
- `avalonst_source_empty`  out  EMPTY_W  forwarded empty.
- `avalonst_source_startofpacket`  out  1  forwarded sop.
- `avalonst_source_endofpacket`  out  1  forwarded eop.
- `avalonst_source_error`  out  1  constant 0.
- `avalonst_source_valid`  out  1  beat present.
- `avalonst_source_ready`  in  1  consumer ready; ready latency 1.
- `level`  out  DEPTH_LOG2+1  committed beats held.
- `pkt_count`  out  16  committed packets held.
- `drop_count`  out  16  dropped packets, saturating at 0xFFFF.

## Operation
- Stored word: {sop, eop, empty, data}, DATA_W+EMPTY_W+2 bits.
- Pointers `wr_ptr`, `commit_ptr`, `rd_ptr` are DEPTH_LOG2+1 bits. Full means `wr_ptr - rd_ptr == 2^DEPTH_LOG2`. Readable means `rd_ptr != commit_ptr`.
- Write FSM states:
  - IDLE:
    - Beat with sop: write it and go to RECV.
    - Beat without sop: discard it, increment drop_count, stay in IDLE.
  - RECV:
    - Beat without sop: write it.
    - Beat with sop: rewind `wr_ptr` to `commit_ptr`, increment drop_count, write the beat as a new packet, stay in RECV.
  - DROP:
    - Discard beats.
    - eop: go to IDLE. sop: handled as in IDLE.
- The eop beat is processed after it is written:
  - error=0: `commit_ptr <= wr_ptr+1`, pkt_count+1, go to IDLE.
  - error=1: rewind `wr_ptr` to `commit_ptr`, drop_count+1, go to IDLE.
- Overflow: a beat arriving while full is not written. Rewind to `commit_ptr` and increment drop_count. Go to DROP, or to IDLE if that beat carries eop.
- A single-beat packet (sop and eop together) commits or drops within one cycle.
- Read side:
  - When `avalonst_source_ready` is 1 and the FIFO is readable in cycle N: read `rd_ptr`, increment it, and increment pkt_count-decrement-on-eop bookkeeping.
  - The word appears with `avalonst_source_valid`=1 in cycle N+1.
  - Otherwise valid is 0 in N+1. Output data holds its last value when valid=0.
- Simultaneous events:
  - A read and a write in the same cycle are both performed.
  - Full is evaluated on pre-edge pointers, so a same-cycle read does not make room.
  - pkt_count: commit and eop-read in the same cycle leaves it unchanged.
- `level = commit_ptr - rd_ptr`.

## Timing
- Reset values: valid 0, sink_ready 0, level 0, pkt_count 0, drop_count 0, source data/empty/sop/eop 0, FSM in IDLE, all pointers 0.
- Reset asserted mid-packet or mid-read loses all contents; no beat is emitted after release until a new packet commits.
- sink_ready rises in the first cycle after reset release.
- Commit latency: eop accepted in cycle N; earliest source valid is in cycle N+2, with ready=1 in N+1.
- Read RAM has registered output; there is no combinational path from sink to source.
- Throughput is one beat per cycle in each direction.

## Structure
- Package `sonic_vc_pkg`:
  - word layout offsets (sop, eop, empty, data);
  - the FSM state enum {IDLE, RECV, DROP};
  - the counter width constant (16).
- Sub-module `sonic_vc_rx_pkt_ram`: simple dual-port RAM (one write port, one read port) with a registered read, sized 2^DEPTH_LOG2 x word width.
- Pointer logic, FSM and counters live in the top module.

## Test plan
- 4-beat packet, error=0, source_ready=1: beats emerge in order with sop on beat 0 and eop on beat 3; first valid is 2 cycles after eop; pkt_count goes 1→0; drop_count=0.
- 3-beat packet with error=1 on eop, then a good 2-beat packet: only the 2-beat packet is output; drop_count=1; level peaks at 2.
- sop-only 2 beats, then a new sop packet of 2 beats with eop: the first packet is discarded; the second is output intact; drop_count=1.
- DEPTH_LOG2=4 with source_ready=0: a 20-beat packet overflows at beat 17; remaining beats are dropped to eop; level=0; drop_count=1; the next 4-beat packet commits with level=4.
- 10 back-to-back single-beat packets with source_ready toggling 1/0: exactly 10 beats output, each with sop=eop=1, valid following ready by 1 cycle.
- reset_n pulsed low while 3 committed packets are held and one packet is partial: all outputs return to reset values; no stale beat appears after release.
